recovery_lock_ctrl: RTL and testbench

- Sequences one event_recovery instance: enables it, waits a settle period, qualifies edges on its primary clock until lock, then monitors for loss.
- On loss it retries, optionally swapping source_select between io_clk_i.pos and io_clk_i.neg, and declares a fault after a bounded number of retries.
- Sits beside event_recovery in the recovery wrapper.
- Drives recovery_en_i, source_select_i and recovery_mode_i of event_recovery; observes its primary_clk_o.

---
 rtl/clks_alot_p.sv | 12 +
 rtl/common_p.sv | 7 +
 rtl/lock_gap_timer.sv | 33 +++
 rtl/recovery_lock_ctrl.sv | 101 ++++++++++
 tb/tb_recovery_lock_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/clks_alot_p.sv
// clks_alot_p: recovery types shared by event_recovery and its lock controller
package clks_alot_p;
  typedef struct packed {
    logic both_edges;
    logic invert;
  } input_mode_s;
  typedef enum logic [2:0] {IDLE, ARM, ACQUIRE, LOCKED, LOST, FAULT} lock_state_e;
  typedef struct packed {
    input_mode_s mode;
    logic source_select;
  } lock_cfg_s;
endpackage

// File: rtl/common_p.sv
// common_p: clock/reset domain bundle shared across blocks
package common_p;
  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;
endpackage

// File: rtl/lock_gap_timer.sv
// lock_gap_timer: primary edge-gap timer and lock edge counter
module lock_gap_timer #(
  parameter int TIMEOUT_W = 16,
  parameter int LOCK_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic                 edge_det,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [LOCK_W-1:0]    lock_edges,
  output logic                 lock_hit,
  output logic                 timeout_hit
);
  logic [TIMEOUT_W-1:0] gap;
  logic [LOCK_W-1:0] cnt, cnt_inc, target;
  always_comb begin
    cnt_inc = cnt + LOCK_W'(1);
    target = lock_edges == '0 ? LOCK_W'(1) : lock_edges;
    lock_hit = active && edge_det && cnt_inc == target;
    timeout_hit = active && !edge_det && timeout != '0 && gap == timeout;
  end
  // both counters saturate so a long gap or a long lock never aliases
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      gap <= '0;
      cnt <= '0;
    end else begin
      gap <= edge_det ? '0 : gap == '1 ? gap : gap + TIMEOUT_W'(1);
      cnt <= edge_det && cnt != '1 ? cnt_inc : cnt;
    end
  end
endmodule

// File: rtl/recovery_lock_ctrl.sv
// recovery_lock_ctrl: arms event_recovery, qualifies lock on its primary clock and retries on loss
module recovery_lock_ctrl import common_p::*, clks_alot_p::*; #(
  parameter int TIMEOUT_W = 16,
  parameter int LOCK_W = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRIES = 4,
  parameter int LOSS_CNT_W = 8
) (
  input  clk_dom_s                           sys_dom_i,
  input  logic                               ctrl_en_i,
  input  input_mode_s                        cfg_mode_i,
  input  logic                               cfg_source_select_i,
  input  logic                               cfg_auto_swap_i,
  input  logic [TIMEOUT_W-1:0]               cfg_timeout_i,
  input  logic [LOCK_W-1:0]                  cfg_lock_edges_i,
  input  logic                               primary_clk_i,
  output logic                               recovery_en_o,
  output logic                               source_select_o,
  output input_mode_s                        recovery_mode_o,
  output logic                               locked_o,
  output logic                               fault_o,
  output lock_state_e                        state_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count_o,
  output logic [LOSS_CNT_W-1:0]              loss_count_o
);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  logic clk, rst;
  lock_state_e state, next;
  logic prev, edge_det, active, settle_done, lock_hit, timeout_hit;
  logic [SETTLE_W-1:0] settle;
  logic [RETRY_W-1:0] retry_inc;
  lock_cfg_s cfg;
  logic [TIMEOUT_W-1:0] timeout;
  logic [LOCK_W-1:0] lock_edges;
  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.sync_rst;
  assign edge_det = primary_clk_i ^ prev;
  assign active = state == ACQUIRE || state == LOCKED;
  assign settle_done = settle == SETTLE_W'(SETTLE_CYCLES - 1);
  assign retry_inc = retry_count_o + RETRY_W'(1);
  assign state_o = state;
  assign source_select_o = cfg.source_select;
  assign recovery_mode_o = cfg.mode;
  lock_gap_timer #(.TIMEOUT_W(TIMEOUT_W), .LOCK_W(LOCK_W)) u_gap (
    .clk(clk),
    .rst(rst),
    .active(active),
    .edge_det(edge_det),
    .timeout(timeout),
    .lock_edges(lock_edges),
    .lock_hit(lock_hit),
    .timeout_hit(timeout_hit)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = ARM;
      ARM:     next = settle_done ? ACQUIRE : ARM;
      ACQUIRE: next = lock_hit ? LOCKED : timeout_hit ? LOST : ACQUIRE;
      LOCKED:  next = timeout_hit ? LOST : LOCKED;
      LOST:    next = retry_inc == RETRY_W'(MAX_RETRIES) ? FAULT : ARM;
      FAULT:   next = FAULT;
      default: next = IDLE;
    endcase
    if (!ctrl_en_i) next = IDLE;
  end
  // outputs are registered from the next state so they line up with state_o
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev <= 1'b0;
      settle <= '0;
      cfg <= '0;
      timeout <= '0;
      lock_edges <= '0;
      retry_count_o <= '0;
      loss_count_o <= '0;
      recovery_en_o <= 1'b0;
      locked_o <= 1'b0;
      fault_o <= 1'b0;
    end else begin
      state <= next;
      prev <= primary_clk_i;
      settle <= state == ARM ? settle + SETTLE_W'(1) : '0;
      if (state == IDLE && ctrl_en_i) begin
        cfg <= {cfg_mode_i, cfg_source_select_i};
        timeout <= cfg_timeout_i;
        lock_edges <= cfg_lock_edges_i;
      end else if (state == LOST && cfg_auto_swap_i) begin
        cfg.source_select <= !cfg.source_select;
      end
      retry_count_o <= next == IDLE ? '0 : state == LOST ? retry_inc : retry_count_o;
      if (state == LOCKED && next == LOST && loss_count_o != '1)
        loss_count_o <= loss_count_o + LOSS_CNT_W'(1);
      recovery_en_o <= next inside {ARM, ACQUIRE, LOCKED};
      locked_o <= next == LOCKED;
      fault_o <= next == FAULT;
    end
  end
endmodule

// File: tb/tb_recovery_lock_ctrl.sv
// tb_recovery_lock_ctrl: scoreboard bench against a cycle model plus directed scenario checks
module tb_recovery_lock_ctrl;
  import common_p::*;
  import clks_alot_p::*;
  localparam int TW = 16, LW = 8, SC = 4, MR = 4, LCW = 8;
  typedef struct packed {
    logic [2:0] st;
    logic en, sel;
    logic [1:0] mode;
    logic lk, ft;
    logic [2:0] rt;
    logic [7:0] ls;
  } obs_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  clk_dom_s dom;
  assign dom = {clk, rst};
  logic en, sel, swap, prim;
  input_mode_s mode;
  logic [TW-1:0] tmo;
  logic [LW-1:0] lke;
  logic rec_en, sel_o, locked, fault;
  input_mode_s mode_o;
  lock_state_e st;
  logic [2:0] retry;
  logic [LCW-1:0] loss;
  recovery_lock_ctrl #(.TIMEOUT_W(TW), .LOCK_W(LW), .SETTLE_CYCLES(SC), .MAX_RETRIES(MR), .LOSS_CNT_W(LCW)) dut (
    .sys_dom_i(dom),
    .ctrl_en_i(en),
    .cfg_mode_i(mode),
    .cfg_source_select_i(sel),
    .cfg_auto_swap_i(swap),
    .cfg_timeout_i(tmo),
    .cfg_lock_edges_i(lke),
    .primary_clk_i(prim),
    .recovery_en_o(rec_en),
    .source_select_o(sel_o),
    .recovery_mode_o(mode_o),
    .locked_o(locked),
    .fault_o(fault),
    .state_o(st),
    .retry_count_o(retry),
    .loss_count_o(loss)
  );
  int checks = 0, errors = 0, cyc = 0, last_edge = 0, per = 0;
  logic prim_q = 1'b0;
  obs_t exp_q[$];
  lock_state_e m_state = IDLE;
  int m_settle = 0, m_gap = 0, m_cnt = 0, m_retry = 0, m_loss = 0, m_tmo = 0, m_lke = 0;
  logic m_prev = 1'b0, m_sel = 1'b0, m_en = 1'b0, m_lk = 1'b0, m_ft = 1'b0;
  logic [1:0] m_mode = 2'b00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_step();
    logic e, act, lh, th;
    lock_state_e ns;
    int tgt;
    e = prim ^ m_prev;
    if (rst) begin
      m_state = IDLE; m_prev = 0; m_settle = 0; m_gap = 0; m_cnt = 0; m_retry = 0; m_loss = 0;
      m_tmo = 0; m_lke = 0; m_sel = 0; m_mode = 0; m_en = 0; m_lk = 0; m_ft = 0;
      return;
    end
    act = m_state == ACQUIRE || m_state == LOCKED;
    tgt = m_lke == 0 ? 1 : m_lke;
    lh = act && e && m_cnt + 1 == tgt;
    th = act && !e && m_tmo != 0 && m_gap == m_tmo;
    if (!en) ns = IDLE;
    else if (m_state == IDLE) ns = ARM;
    else if (m_state == ARM) ns = m_settle == SC - 1 ? ACQUIRE : ARM;
    else if (lh) ns = LOCKED;
    else if (th) ns = LOST;
    else if (m_state == LOST) ns = m_retry + 1 == MR ? FAULT : ARM;
    else ns = m_state;
    if (m_state == LOCKED && ns == LOST && m_loss < 255) m_loss++;
    if (ns == IDLE) m_retry = 0;
    else if (m_state == LOST) m_retry++;
    if (m_state == IDLE && en) begin
      m_sel = sel; m_mode = mode; m_tmo = tmo; m_lke = lke;
    end else if (m_state == LOST && swap) m_sel = !m_sel;
    m_settle = m_state == ARM ? m_settle + 1 : 0;
    if (!act) begin
      m_gap = 0; m_cnt = 0;
    end else if (e) begin
      m_gap = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (m_gap < 65535) m_gap++;
    m_prev = prim;
    m_en = ns inside {ARM, ACQUIRE, LOCKED};
    m_lk = ns == LOCKED;
    m_ft = ns == FAULT;
    m_state = ns;
  endtask
  function automatic obs_t model_obs();
    return {m_state, m_en, m_sel, m_mode, m_lk, m_ft, 3'(m_retry), 8'(m_loss)};
  endfunction
  function automatic obs_t dut_obs();
    return {st, rec_en, sel_o, mode_o, locked, fault, retry, loss};
  endfunction
  task automatic tick();
    obs_t e;
    cyc++;
    if (prim != prim_q) last_edge = cyc;
    prim_q = prim;
    model_step();
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb", dut_obs(), e);
  endtask
  task automatic step();
    if (per != 0 && (cyc + 1) % per == 0) prim = ~prim;
    tick();
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic wait_st(input lock_state_e s, input int max, input string tag);
    int n = 0;
    while (st != s && n < max) begin
      step();
      n++;
    end
    chk(tag, st, s);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1);
  end
  initial begin
    int arm_n, edges, k0, n_arm;
    logic [3:0] seq;
    lock_state_e pst;
    en = 0; sel = 0; swap = 0; prim = 0; mode = '0; tmo = '0; lke = '0;
    run(3);
    chk("rst_outs", dut_obs(), 0);
    rst = 0;
    run(2);
    // basic lock: ARM for SETTLE cycles, lock on the 3rd qualified edge
    tmo = 20; lke = 3; per = 5; mode = input_mode_s'(2'b10); sel = 0;
    en = 1;
    step();
    chk("arm_first", st, ARM);
    chk("arm_en", rec_en, 1);
    arm_n = 1;
    while (st == ARM && arm_n < 50) begin
      step();
      if (st == ARM) arm_n++;
    end
    chk("arm_cycles", arm_n, 4);
    chk("acq_after_arm", st, ACQUIRE);
    edges = 0;
    while (st == ACQUIRE && edges < 20) begin
      step();
      if (last_edge == cyc) edges++;
    end
    chk("lock_edges", edges, 3);
    chk("locked", locked, 1);
    chk("lock_retry", retry, 0);
    // config changes while locked must not reach the outputs
    sel = 1; mode = input_mode_s'(2'b01);
    run(15);
    chk("iso_sel", sel_o, 0);
    chk("iso_mode", mode_o, 2'b10);
    chk("iso_state", st, LOCKED);
    // tie: edge lands in the cycle the gap timer equals the timeout
    per = 0;
    while (cyc < last_edge + 20) step();
    prim = ~prim;
    step();
    chk("tie_locked", st, LOCKED);
    // loss: timer reaches 20 on the 21st posedge after the edge posedge
    k0 = last_edge;
    wait_st(LOST, 40, "lost_reach");
    chk("lost_time", cyc - k0, 21);
    chk("loss_cnt", loss, 1);
    chk("lost_en", rec_en, 0);
    step();
    chk("lost_to_arm", st, ARM);
    chk("rearm_en", rec_en, 1);
    chk("rearm_retry", retry, 1);
    // abort from ACQUIRE
    wait_st(ACQUIRE, 10, "acq_reach");
    en = 0;
    step();
    chk("abort_idle", st, IDLE);
    chk("abort_en", rec_en, 0);
    chk("abort_retry", retry, 0);
    // timeout disabled: ACQUIRE holds with no edges
    tmo = 0; en = 1;
    run(300);
    chk("notmo_acq", st, ACQUIRE);
    chk("notmo_retry", retry, 0);
    en = 0;
    step();
    // auto-swap retries into FAULT
    tmo = 10; sel = 1; swap = 1; en = 1;
    seq = '0; n_arm = 0; pst = st;
    for (int n = 0; n < 400 && st != FAULT; n++) begin
      step();
      if (st == ARM && pst != ARM) begin
        if (n_arm < 4) seq[n_arm] = sel_o;
        n_arm++;
      end
      pst = st;
    end
    chk("arm_entries", n_arm, 4);
    chk("swap_seq", seq, 4'b0101);
    chk("fault", fault, 1);
    chk("fault_en", rec_en, 0);
    chk("fault_retry", retry, 4);
    chk("fault_loss", loss, 1);
    run(5);
    chk("fault_hold", st, FAULT);
    en = 0;
    step();
    chk("fault_idle", st, IDLE);
    chk("idle_retry", retry, 0);
    // synchronous reset while locked
    swap = 0; tmo = 20; per = 5; en = 1;
    wait_st(LOCKED, 100, "relock");
    rst = 1;
    step();
    chk("rst_lock", dut_obs(), 0);
    rst = 0; en = 0;
    run(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
